// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver for common-anode digit banks with leading-zero
// blanking, decimal points, 16-level brightness PWM, dead time and per-frame snapshot.
module hex7segment (
    input  logic [3:0] x,
    output logic [6:0] z
);
    // Active-low segments ordered {g,f,e,d,c,b,a}
    always_comb begin
        z = 7'h7F;
        case (x)
            4'h0: z = 7'h40;
            4'h1: z = 7'h79;
            4'h2: z = 7'h24;
            4'h3: z = 7'h30;
            4'h4: z = 7'h19;
            4'h5: z = 7'h12;
            4'h6: z = 7'h02;
            4'h7: z = 7'h78;
            4'h8: z = 7'h00;
            4'h9: z = 7'h10;
            4'hA: z = 7'h08;
            4'hB: z = 7'h03;
            4'hC: z = 7'h46;
            4'hD: z = 7'h21;
            4'hE: z = 7'h06;
            4'hF: z = 7'h0E;
            default: z = 7'h7F;
        endcase
    end
endmodule

module hex_scan_display #(
    parameter int NDIGITS      = 4,
    parameter int HOLD_CYCLES  = 256,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [4*NDIGITS-1:0]   dataword_i,
    input  logic [NDIGITS-1:0]     dp_i,
    input  logic                   blank_lz_i,
    input  logic [3:0]             brightness_i,
    output logic [NDIGITS-1:0]     sel_o,
    output logic [7:0]             seg_o,
    output logic                   frame_done_o
);
    localparam int DW = $clog2(NDIGITS);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {BLANK, LOAD, ON} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        digit_q, digit_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [BW-1:0]        blank_q, blank_d;
    logic [4*NDIGITS-1:0] dataSnap_q, dataSnap_d;
    logic [NDIGITS-1:0]   dpSnap_q, dpSnap_d;
    logic                 lzSnap_q, lzSnap_d;
    logic [NDIGITS-1:0]   sel_q, sel_d;
    logic [7:0]           seg_q, seg_d;
    logic                 frameDone_q, frameDone_d;

    logic [3:0]           nibble;
    logic                 dpBit;
    logic                 upperNonZero;
    logic                 blanked;
    logic [6:0]           decoded;

    hex7segment u_decoder (
        .x (nibble),
        .z (decoded)
    );

    // The LOAD of digit 0 decodes straight from the inputs it is capturing this cycle
    always_comb begin
        dataSnap_d = dataSnap_q;
        dpSnap_d   = dpSnap_q;
        lzSnap_d   = lzSnap_q;
        if (state_q == LOAD && digit_q == '0) begin
            dataSnap_d = dataword_i;
            dpSnap_d   = dp_i;
            lzSnap_d   = blank_lz_i;
        end
    end

    always_comb begin
        nibble       = 4'h0;
        dpBit        = 1'b0;
        upperNonZero = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (int'(digit_q) == i) begin
                nibble = dataSnap_d[4*i +: 4];
                dpBit  = dpSnap_d[i];
            end
            if (i >= int'(digit_q) && dataSnap_d[4*i +: 4] != 4'h0) begin
                upperNonZero = 1'b1;
            end
        end
        blanked = lzSnap_d && (digit_q != '0) && !upperNonZero;
    end

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        hold_d      = hold_q;
        blank_d     = blank_q;
        seg_d       = 8'hFF;
        sel_d       = '1;
        frameDone_d = 1'b0;
        case (state_q)
            BLANK: begin
                if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                    blank_d = '0;
                    state_d = LOAD;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = ON;
                hold_d  = '0;
                seg_d   = {~dpBit, blanked ? 7'h7F : decoded};
            end
            ON: begin
                seg_d = seg_q;
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = BLANK;
                    seg_d   = 8'hFF;
                    if (digit_q == DW'(NDIGITS - 1)) begin
                        digit_d = '0;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        if (state_d == ON) begin
            frameDone_d = (hold_d == HW'(HOLD_CYCLES - 1)) && (digit_q == DW'(NDIGITS - 1));
            for (int i = 0; i < NDIGITS; i++) begin
                if (int'(digit_q) == i && hold_d[3:0] <= brightness_i) begin
                    sel_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= BLANK;
            digit_q     <= '0;
            hold_q      <= '0;
            blank_q     <= '0;
            dataSnap_q  <= '0;
            dpSnap_q    <= '0;
            lzSnap_q    <= 1'b0;
            sel_q       <= '1;
            seg_q       <= 8'hFF;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            hold_q      <= hold_d;
            blank_q     <= blank_d;
            dataSnap_q  <= dataSnap_d;
            dpSnap_q    <= dpSnap_d;
            lzSnap_q    <= lzSnap_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign sel_o        = sel_q;
    assign seg_o        = seg_q;
    assign frame_done_o = frameDone_q;
endmodule
